// File: rtl/key_pio_edge_irq.sv
// Parametrised Avalon-MM key PIO: synchronised inputs, per-bit sticky edge capture, maskable level irq.
// Optional per-bit debounce filter is compiled in with `define KEY_DEBOUNCE_EN.
module key_pio_edge_irq #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 1,
  parameter int IDLE_LEVEL      = 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [WIDTH-1:0] IDLE_VEC = (IDLE_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] clean_s;
  logic [WIDTH-1:0] clean_dly_q;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr_s;
  logic             unused_wd_s;

  assign wr_s        = chipselect & ~write_n;
  assign sync_s      = sync_q[SYNC_STAGES-1];
  assign unused_wd_s = ^writedata;

  // Input synchroniser chain, stage 0 samples the raw pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{IDLE_VEC}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam logic [15:0] DEB_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]       deb_q, deb_d;
  logic [WIDTH-1:0][15:0] cnt_q, cnt_d;

  // A bit only follows the synchroniser after disagreeing for DEBOUNCE_CYCLES clocks
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_s[i] == deb_q[i]) begin
        cnt_d[i] = 16'd0;
      end else if (cnt_q[i] == DEB_MAX) begin
        deb_d[i] = sync_s[i];
        cnt_d[i] = 16'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q <= IDLE_VEC;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign clean_s = deb_q;
`else
  assign clean_s = sync_s;
`endif

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_s = clean_s & ~clean_dly_q;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_s = ~clean_s & clean_dly_q;
    end else begin : g_any
      assign edge_s = clean_s ^ clean_dly_q;
    end
  endgenerate

  // Register next-state: a fresh edge beats a same-cycle W1C on the same bit
  always_comb begin
    cap_d      = cap_q | edge_s;
    mask_d     = mask_q;
    readdata_d = 32'd0;
    irq_d      = |(cap_q & mask_q);
    if (wr_s && (address == 2'd3)) begin
      cap_d = (cap_q & ~writedata[WIDTH-1:0]) | edge_s;
    end else begin
      cap_d = cap_q | edge_s;
    end
    if (wr_s && (address == 2'd2)) begin
      mask_d = writedata[WIDTH-1:0];
    end else begin
      mask_d = mask_q;
    end
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = clean_s;
      2'd2:    readdata_d[WIDTH-1:0] = mask_q;
      2'd3:    readdata_d[WIDTH-1:0] = cap_q;
      default: readdata_d = 32'd0;
    endcase
  end

  // Edge history, capture, mask and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clean_dly_q <= IDLE_VEC;
      cap_q       <= '0;
      mask_q      <= '0;
      readdata_q  <= 32'd0;
      irq_q       <= 1'b0;
    end else begin
      clean_dly_q <= clean_s;
      cap_q       <= cap_d;
      mask_q      <= mask_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: doc/key_pio_edge_irq.md
Name: key_pio_edge_irq

Overview:
- Parametrised successor to the fixed 32-bit input-only key PIO.
- Avalon-MM slave that samples a WIDTH-bit push-button/switch bus through a synchroniser and captures edges per bit.
- Raises a maskable, level-sensitive interrupt to the Nios II system.
- Sits between board key pins and the system interconnect.

Parameters:
- WIDTH, 4: number of input channels (1..32).
- SYNC_STAGES, 2: synchroniser flip-flop depth (2..4).
- EDGE_TYPE, 1: capture mode. 0 = rising, 1 = falling, 2 = any edge.
- IDLE_LEVEL, 1: reset value of the synchroniser and history flops (1 suits active-low keys).
- DEBOUNCE_CYCLES, 16: stable-count threshold. Used only with KEY_DEBOUNCE_EN; range 2..65535.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  raw asynchronous key inputs
- readdata  out  32  registered read data
- irq  out  1  interrupt request, active-high

Behaviour:
Clock and reset:
- Reset reset_n, asynchronous, active-low; clock clk.
- Reset values:
  - readdata = 0, irq = 0, irq_mask = 0, edge_capture = 0.
  - All synchroniser, history and debounce-output flops = {WIDTH{IDLE_LEVEL}}.
  - Debounce counters = 0.
- Reset asserted mid-operation clears all pending captures and the mask immediately. No edge may be flagged in the cycles after release while inputs stay at IDLE_LEVEL.

Input path:
- in_port passes through SYNC_STAGES flops, giving sync_q.
- clean = sync_q, or the debounced value when the optional feature is compiled in.
- clean_d = clean delayed one cycle.

Edge detection, per bit i:
- rise = clean & ~clean_d; fall = ~clean & clean_d.
- Selected edge set by EDGE_TYPE: rise, fall, or rise|fall.
- Pin-to-capture latency without debounce: SYNC_STAGES+1 cycles from the in_port change to edge_capture[i] = 1.

Register map:
- Word addresses; unused readdata bits read 0.
- 0 DATA (RO): clean[WIDTH-1:0]. Writes are ignored.
- 1 reserved: reads 0, writes ignored.
- 2 IRQ_MASK (RW): bits [WIDTH-1:0]. Written when chipselect=1, write_n=0, address=2.
- 3 EDGE_CAPTURE (R/W1C): a write clears every bit i with writedata[i]=1. Bits with writedata[i]=0 are unchanged.

Write/capture rules:
- A detected edge and a W1C clear on the same bit in the same cycle: set wins, bit stays 1.
- Captured bits are sticky until cleared; repeated edges have no further effect.

Read timing:
- Every clk, readdata <= mux(address), independent of chipselect/read.
- Read latency is 1 cycle.
- A read of EDGE_CAPTURE in the same cycle as a W1C returns the pre-clear value.

Interrupt:
- irq = |(edge_capture & irq_mask), registered: one cycle after the capture or mask update.
- irq stays asserted until all masked captured bits are cleared or masked off.

Optional Feature:
- Macro KEY_DEBOUNCE_EN.
- Defined:
  - Each bit has a 16-bit counter.
  - While sync_q[i] == deb_q[i], the counter resets to 0.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES-1, deb_q[i] <= sync_q[i] and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes DATA or triggers capture.
  - Latency becomes SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
- Undefined: no counters are generated; clean = sync_q; the DEBOUNCE_CYCLES parameter is unused.

Test Plan:
1. Reset release with in_port=4'hF held (IDLE_LEVEL=1) for 20 cycles -> readdata at addr 0 = 32'h0000000F; addr 3 = 0; irq=0 throughout.
2. EDGE_TYPE=1, mask written 4'h5, in_port 4'hF->4'hE -> edge_capture=4'h1 at SYNC_STAGES+1 cycles, irq=1 one cycle later. Write 32'h1 to addr 3 -> capture 0, irq drops next cycle.
3. Unmasked capture: mask=4'h1, in_port bit1 falls -> edge_capture=4'h2, irq stays 0. Then write mask=4'h3 -> irq=1 one cycle later.
4. Simultaneous set/clear: bit0 falling edge arrives in the same cycle as a W1C 32'h1 to addr 3 -> edge_capture[0] remains 1.
5. EDGE_TYPE=2: toggle bit3 0->1->0 with 10-cycle gaps, clearing between toggles -> both transitions captured (4'h8 each time).
6. KEY_DEBOUNCE_EN, DEBOUNCE_CYCLES=16:
   - a 10-cycle low pulse on bit0 -> DATA stays 4'hF, no capture.
   - a 40-cycle low pulse -> DATA=4'hE and capture=4'h1 exactly SYNC_STAGES+17 cycles after the fall.
